// File: rtl/signal_conditioner.sv
// Multi-channel async input conditioner: N-flop synchroniser, tick-qualified debounce, edge pulses.
// Latency: SYNC_STAGES + max(FILTER_CYCLES,1) clk edges from first capture to synchron_signal_out.
// Backpressure: none; free-running level path, pulses are single-cycle and unconditional.
module signal_conditioner #(
    parameter int               WIDTH         = 1,
    parameter int               SYNC_STAGES   = 2,
    parameter int               FILTER_CYCLES = 0,
    parameter logic [WIDTH-1:0] RESET_VALUE   = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] asynchron_signal_in,
    input  logic             filter_tick,
    output logic [WIDTH-1:0] synchron_signal_out,
    output logic [WIDTH-1:0] rising_edge_pulse,
    output logic [WIDTH-1:0] falling_edge_pulse,
    output logic             change_event
);

    generate
        if (SYNC_STAGES < 2) begin : g_bad_stages
            $error("signal_conditioner: SYNC_STAGES must be at least 2");
        end
    endgenerate

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_s;
    logic [WIDTH-1:0] filt_q;
    logic [WIDTH-1:0] hist_q;

    // Only stage 0 ever samples the raw asynchronous input.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int j = 0; j < SYNC_STAGES; j++) begin
                sync_q[j] <= RESET_VALUE;
            end
        end else begin
            sync_q[0] <= asynchron_signal_in;
            for (int j = 1; j < SYNC_STAGES; j++) begin
                sync_q[j] <= sync_q[j-1];
            end
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

    generate
        if (FILTER_CYCLES == 0) begin : g_no_filter
            logic unused_tick;
            assign unused_tick = filter_tick;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    filt_q <= RESET_VALUE;
                end else begin
                    filt_q <= sync_s;
                end
            end
        end else begin : g_filter
            localparam int CNT_W = (FILTER_CYCLES > 0) ? $clog2(FILTER_CYCLES + 1) : 1;
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

            logic [CNT_W-1:0] cnt_q [WIDTH];

            // Count consecutive qualified samples that disagree with the accepted level;
            // any sample agreeing with it restarts the count regardless of the tick.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    filt_q <= RESET_VALUE;
                    for (int i = 0; i < WIDTH; i++) begin
                        cnt_q[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (sync_s[i] == filt_q[i]) begin
                            cnt_q[i] <= '0;
                        end else if (filter_tick) begin
                            if (cnt_q[i] == CNT_LAST) begin
                                filt_q[i] <= sync_s[i];
                                cnt_q[i]  <= '0;
                            end else begin
                                cnt_q[i] <= cnt_q[i] + 1'b1;
                            end
                        end
                    end
                end
            end
        end
    endgenerate

    // History resets to the same level as the output so reset release never makes a pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_q <= RESET_VALUE;
        end else begin
            hist_q <= filt_q;
        end
    end

    assign synchron_signal_out = filt_q;
    assign rising_edge_pulse   = filt_q & ~hist_q;
    assign falling_edge_pulse  = ~filt_q & hist_q;
    assign change_event        = |(filt_q ^ hist_q);

endmodule

// File: tb/tb_signal_conditioner.sv
// Bench for signal_conditioner: three configurations checked against a queue-free behavioural model.
module tb_signal_conditioner;

    logic       clk;
    logic       reset;
    logic [3:0] in_a, in_c;
    logic       in_b;
    logic       tick_a, tick_b, tick_c;
    logic [3:0] out_a, rise_a, fall_a;
    logic [3:0] out_c, rise_c, fall_c;
    logic       out_b, rise_b, fall_b;
    logic       chg_a, chg_b, chg_c;

    int checks = 0;
    int errors = 0;

    signal_conditioner #(.WIDTH(4), .SYNC_STAGES(3), .FILTER_CYCLES(4), .RESET_VALUE(4'b0000)) dut_a (
        .clk(clk), .reset(reset), .asynchron_signal_in(in_a), .filter_tick(tick_a),
        .synchron_signal_out(out_a), .rising_edge_pulse(rise_a), .falling_edge_pulse(fall_a),
        .change_event(chg_a));

    signal_conditioner #(.WIDTH(1), .SYNC_STAGES(2), .FILTER_CYCLES(0), .RESET_VALUE(1'b0)) dut_b (
        .clk(clk), .reset(reset), .asynchron_signal_in(in_b), .filter_tick(tick_b),
        .synchron_signal_out(out_b), .rising_edge_pulse(rise_b), .falling_edge_pulse(fall_b),
        .change_event(chg_b));

    signal_conditioner #(.WIDTH(4), .SYNC_STAGES(2), .FILTER_CYCLES(3), .RESET_VALUE(4'b1010)) dut_c (
        .clk(clk), .reset(reset), .asynchron_signal_in(in_c), .filter_tick(tick_c),
        .synchron_signal_out(out_c), .rising_edge_pulse(rise_c), .falling_edge_pulse(fall_c),
        .change_event(chg_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: input delay line, then per-channel run length of qualified disagreeing samples.
    localparam int         P_W  [3] = '{4, 1, 4};
    localparam int         P_S  [3] = '{3, 2, 2};
    localparam int         P_F  [3] = '{4, 0, 3};
    localparam logic [3:0] P_RV [3] = '{4'b0000, 4'b0000, 4'b1010};

    logic [3:0] m_pipe [3][4];
    logic [3:0] m_out  [3];
    logic [3:0] m_prev [3];
    int         m_run  [3][4];

    task automatic model_reset(input int k);
        for (int j = 0; j < 4; j++) m_pipe[k][j] = P_RV[k];
        for (int ch = 0; ch < 4; ch++) m_run[k][ch] = 0;
        m_out[k]  = P_RV[k];
        m_prev[k] = P_RV[k];
    endtask

    task automatic model_step(input int k, input logic [3:0] din, input logic tick);
        logic [3:0] s;
        s = m_pipe[k][P_S[k]-1];
        for (int j = 3; j > 0; j--) m_pipe[k][j] = m_pipe[k][j-1];
        m_pipe[k][0] = din;
        m_prev[k] = m_out[k];
        for (int ch = 0; ch < P_W[k]; ch++) begin
            if (P_F[k] == 0) begin
                m_out[k][ch] = s[ch];
            end else if (s[ch] == m_out[k][ch]) begin
                m_run[k][ch] = 0;
            end else if (tick) begin
                m_run[k][ch] = m_run[k][ch] + 1;
                if (m_run[k][ch] >= P_F[k]) begin
                    m_out[k][ch] = s[ch];
                    m_run[k][ch] = 0;
                end
            end
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 3; k++) model_reset(k);
        end else begin
            model_step(0, in_a, tick_a);
            model_step(1, {3'b000, in_b}, tick_b);
            model_step(2, in_c, tick_c);
        end
    end

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("a_out",  out_a, m_out[0]);
        chk("a_rise", rise_a, m_out[0] & ~m_prev[0]);
        chk("a_fall", fall_a, ~m_out[0] & m_prev[0]);
        chk("a_chg",  {3'b000, chg_a}, {3'b000, |(m_out[0] ^ m_prev[0])});
        chk("b_out",  {3'b000, out_b}, {3'b000, m_out[1][0]});
        chk("b_rise", {3'b000, rise_b}, {3'b000, m_out[1][0] & ~m_prev[1][0]});
        chk("b_fall", {3'b000, fall_b}, {3'b000, ~m_out[1][0] & m_prev[1][0]});
        chk("b_chg",  {3'b000, chg_b}, {3'b000, m_out[1][0] ^ m_prev[1][0]});
        chk("c_out",  out_c, m_out[2]);
        chk("c_rise", rise_c, m_out[2] & ~m_prev[2]);
        chk("c_fall", fall_c, ~m_out[2] & m_prev[2]);
        chk("c_chg",  {3'b000, chg_c}, {3'b000, |(m_out[2] ^ m_prev[2])});
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        reset  = 1'b0;
        in_a   = 4'b0000;
        in_b   = 1'b0;
        in_c   = 4'b0101;
        tick_a = 1'b1;
        tick_b = 1'b0;
        tick_c = 1'b1;
        repeat (3) cyc();
        chk("rst_a_out", out_a, 4'b0000);
        chk("rst_b_out", {3'b000, out_b}, 4'b0000);
        chk("rst_c_out", out_c, 4'b1010);
        chk("rst_c_pulse", rise_c | fall_c, 4'b0000);
        chk("rst_chg", {1'b0, chg_a, chg_b, chg_c}, 4'b0000);

        // Release: B sees 0->1, C sees 0101 against its 1010 reset level.
        reset = 1'b1;
        in_b  = 1'b1;
        for (int n = 0; n < 7; n++) begin
            cyc();
            if (n == 1) chk("b_lat_early", {3'b000, out_b}, 4'b0000);
            if (n == 2) begin
                chk("b_lat_out",  {3'b000, out_b}, 4'b0001);
                chk("b_lat_rise", {3'b000, rise_b}, 4'b0001);
            end
            if (n == 3) begin
                chk("b_rise_once", {3'b000, rise_b}, 4'b0000);
                chk("c_lat_early", out_c, 4'b1010);
            end
            if (n == 4) begin
                chk("c_rv_out",  out_c, 4'b0101);
                chk("c_rv_rise", rise_c, 4'b0101);
                chk("c_rv_fall", fall_c, 4'b1010);
                chk("c_rv_chg",  {3'b000, chg_c}, 4'b0001);
            end
            if (n == 5) chk("c_rv_chg_once", {3'b000, chg_c}, 4'b0000);
        end

        // A channel 2: 3-clock glitch must be swallowed.
        for (int n = 0; n < 12; n++) begin
            in_a = (n < 3) ? 4'b0100 : 4'b0000;
            cyc();
            chk("a_glitch_out", out_a, 4'b0000);
            chk("a_glitch_chg", {3'b000, chg_a}, 4'b0000);
        end

        // A channel 2 held high: accepted at edge 3-1+4 = 6.
        for (int n = 0; n < 9; n++) begin
            in_a = 4'b0100;
            cyc();
            if (n == 5) chk("a_hold_early", out_a, 4'b0000);
            if (n == 6) begin
                chk("a_hold_out",  out_a, 4'b0100);
                chk("a_hold_rise", rise_a, 4'b0100);
            end
            if (n == 7) chk("a_hold_rise_once", rise_a, 4'b0000);
        end

        // C channel 1 with a tick every 4th clock: accepted on the 3rd qualified tick.
        for (int n = 0; n < 13; n++) begin
            in_c   = 4'b0111;
            tick_c = (n % 4 == 3);
            cyc();
            if (n == 10) chk("c_tick_early", out_c, 4'b0101);
            if (n == 11) begin
                chk("c_tick_out",  out_c, 4'b0111);
                chk("c_tick_rise", rise_c, 4'b0010);
            end
        end

        // C channel 3: mismatch cleared between ticks must restart the count.
        for (int n = 0; n < 21; n++) begin
            in_c   = {((n <= 3) || (n >= 8)), 3'b111};
            tick_c = (n % 4 == 3);
            cyc();
            if (n == 15) chk("c_clear_restart", out_c, 4'b0111);
            if (n == 18) chk("c_clear_early", out_c, 4'b0111);
            if (n == 19) begin
                chk("c_clear_out",  out_c, 4'b1111);
                chk("c_clear_rise", rise_c, 4'b1000);
            end
        end

        // Async reset while A channel 0 has counted 2 and B shows a falling pulse.
        tick_c = 1'b1;
        for (int n = 0; n < 5; n++) begin
            in_a = 4'b0101;
            in_b = (n >= 2) ? 1'b0 : 1'b1;
            cyc();
        end
        chk("pre_rst_b_fall", {3'b000, fall_b}, 4'b0001);
        chk("pre_rst_a_out", out_a, 4'b0100);
        #2 reset = 1'b0;
        #1;
        chk("arst_a_out",  out_a, 4'b0000);
        chk("arst_b_fall", {3'b000, fall_b}, 4'b0000);
        chk("arst_c_out",  out_c, 4'b1010);
        chk("arst_c_pulse", rise_c | fall_c, 4'b0000);
        chk("arst_chg", {1'b0, chg_a, chg_b, chg_c}, 4'b0000);
        check_all();
        @(negedge clk);
        reset = 1'b1;
        for (int n = 0; n < 8; n++) begin
            cyc();
            if (n == 5) chk("post_rst_a_early", out_a, 4'b0000);
            if (n == 6) begin
                chk("post_rst_a_out",  out_a, 4'b0101);
                chk("post_rst_a_rise", rise_a, 4'b0101);
            end
        end

        // Randomised phase with sparse toggles, random ticks and occasional async reset.
        repeat (400) begin
            if ($urandom_range(0, 5) == 0) in_a ^= 4'(1 << $urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) in_c ^= 4'(1 << $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) in_b = ~in_b;
            tick_a = 1'($urandom_range(0, 1));
            tick_b = 1'($urandom_range(0, 1));
            tick_c = ($urandom_range(0, 2) != 0);
            reset  = ($urandom_range(0, 99) != 0);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
